// File: rtl/queue_pkg.sv
// Shared sizing constants and entry type for the 5x79 queue controller.
package queue_pkg;
  localparam int DEPTH = 5;
  localparam int WIDTH = 79;
  localparam int AW    = 3;

  typedef logic [WIDTH-1:0] entry_t;
endpackage

// File: rtl/queue_ptr_wrap.sv
// Pointer increment that wraps DEPTH-1 back to 0, so codes >= DEPTH never appear.
module queue_ptr_wrap #(
  parameter int DEPTH = 5,
  parameter int AW    = 3
) (
  input  logic [AW-1:0] ptr,
  output logic [AW-1:0] ptr_inc
);
  assign ptr_inc = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
endmodule

// File: rtl/queue_ctrl_5x79.sv
// Circular-queue controller; the entry storage lives outside and is reached
// through the W0 (write) and R0 (combinational read) ports.
module queue_ctrl_5x79
  import queue_pkg::*;
#(
  parameter int DEPTH = queue_pkg::DEPTH,
  parameter int WIDTH = queue_pkg::WIDTH,
  parameter int AW    = queue_pkg::AW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits,
  input  logic             flush,
  output logic [AW-1:0]    count,
  output logic [AW-1:0]    W0_addr,
  output logic             W0_en,
  output logic             W0_clk,
  output logic [WIDTH-1:0] W0_data,
  output logic [AW-1:0]    R0_addr,
  output logic             R0_en,
  output logic             R0_clk,
  input  logic [WIDTH-1:0] R0_data
);
  logic [AW-1:0] enq_ptr_reg, deq_ptr_reg;
  logic [AW-1:0] enq_ptr_inc, deq_ptr_inc;
  logic          maybe_full_reg;
  logic          ptr_match, full, empty;
  logic          enq_fire, deq_fire;
  logic [AW-1:0] ptr_diff;

  queue_ptr_wrap #(.DEPTH(DEPTH), .AW(AW)) u_enq_wrap (
    .ptr     (enq_ptr_reg),
    .ptr_inc (enq_ptr_inc)
  );

  queue_ptr_wrap #(.DEPTH(DEPTH), .AW(AW)) u_deq_wrap (
    .ptr     (deq_ptr_reg),
    .ptr_inc (deq_ptr_inc)
  );

  // Equal pointers are ambiguous; maybe_full records which way we got there.
  assign ptr_match = (enq_ptr_reg == deq_ptr_reg);
  assign full      = ptr_match & maybe_full_reg;
  assign empty     = ptr_match & ~maybe_full_reg;

  assign enq_ready = ~full;
  assign deq_valid = ~empty;
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;

  assign ptr_diff = (enq_ptr_reg >= deq_ptr_reg) ? (enq_ptr_reg - deq_ptr_reg)
                                                 : (enq_ptr_reg + AW'(DEPTH) - deq_ptr_reg);
  assign count    = full ? AW'(DEPTH) : ptr_diff;

  // Write is suppressed during reset so a mid-operation reset leaves storage untouched.
  assign W0_en   = enq_fire & reset;
  assign W0_addr = enq_ptr_reg;
  assign W0_data = enq_bits;
  assign W0_clk  = clock;

  assign R0_en    = 1'b1;
  assign R0_addr  = deq_ptr_reg;
  assign R0_clk   = clock;
  assign deq_bits = R0_data;

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      enq_ptr_reg    <= '0;
      deq_ptr_reg    <= '0;
      maybe_full_reg <= 1'b0;
    end else begin
      if (enq_fire) enq_ptr_reg <= enq_ptr_inc;
      if (deq_fire) deq_ptr_reg <= deq_ptr_inc;
      if (enq_fire != deq_fire) maybe_full_reg <= enq_fire;
    end
  end
endmodule

// File: tb/tb_queue_ctrl_5x79.sv
// Bench for queue_ctrl_5x79: external storage model plus a FIFO reference queue.
module tb_queue_ctrl_5x79;
  import queue_pkg::*;

  localparam int D = 5;
  localparam int W = 79;
  localparam int A = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         enq_valid = 1'b0, deq_ready = 1'b0, flush = 1'b0;
  logic [W-1:0] enq_bits = '0;
  logic         enq_ready, deq_valid;
  logic [W-1:0] deq_bits, W0_data, R0_data;
  logic [A-1:0] count, W0_addr, R0_addr;
  logic         W0_en, W0_clk, R0_en, R0_clk;

  logic [W-1:0] mem [8];
  entry_t       model_q[$];
  int           wr_total = 0, rd_total = 0;
  int           total = 0, bad = 0;

  always #5 clock = ~clock;

  queue_ctrl_5x79 dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
    .flush(flush), .count(count),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_clk(W0_clk), .W0_data(W0_data),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_clk(R0_clk), .R0_data(R0_data)
  );

  // External storage: clocked write, combinational read.
  always @(posedge clock) if (W0_en) mem[W0_addr] <= W0_data;
  assign R0_data = mem[R0_addr];

  task automatic apply(input logic ev, input logic dr, input logic fl, input logic [W-1:0] bits);
    enq_valid = ev;
    deq_ready = dr;
    flush     = fl;
    enq_bits  = bits;
    #1;
  endtask

  // Advance one clock while applying the queue rules to the reference model.
  task automatic tick();
    bit ef, df;
    ef = enq_valid && (model_q.size() < D);
    df = deq_ready && (model_q.size() > 0);
    if (!reset || flush) begin
      model_q.delete();
      wr_total = 0;
      rd_total = 0;
    end else begin
      if (df) begin void'(model_q.pop_front()); rd_total++; end
      if (ef) begin model_q.push_back(enq_bits); wr_total++; end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    apply(0, 0, 0, '0);
    tick();
    tick();
    reset = 1'b1;
    apply(0, 0, 0, '0);
    total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL reset_enq_ready: got %0b want 1", enq_ready); end
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL reset_deq_valid: got %0b want 0", deq_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 3; i++) begin
      apply(1, 0, 0, W'(i));
      if (i == 1) begin
        total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL basic_no_flowthrough: got %0b want 0", deq_valid); end
      end
      tick();
      total++; if (count !== A'(i)) begin bad++; $display("FAIL basic_count: got %0d want %0d", count, i); end
    end
    for (int i = 1; i <= 3; i++) begin
      apply(0, 1, 0, '0);
      total++; if (deq_valid !== 1'b1 || deq_bits !== W'(i)) begin
        bad++; $display("FAIL basic_deq: got valid=%0b data=%0h want valid=1 data=%0h", deq_valid, deq_bits, i);
      end
      tick();
    end
    apply(0, 0, 0, '0);
    total++; if (count !== 3'd0 || deq_valid !== 1'b0) begin
      bad++; $display("FAIL basic_drained: got count=%0d valid=%0b want 0/0", count, deq_valid);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < D; i++) begin
      apply(1, 0, 0, W'(32'h10 + i));
      tick();
    end
    apply(1, 0, 0, W'(32'h99));
    total++; if (enq_ready !== 1'b0 || count !== 3'd5) begin
      bad++; $display("FAIL full_state: got ready=%0b count=%0d want 0/5", enq_ready, count);
    end
    total++; if (W0_en !== 1'b0) begin bad++; $display("FAIL full_sixth_w0en: got %0b want 0", W0_en); end
    tick();
    apply(1, 1, 0, W'(32'hAA));
    total++; if (W0_en !== 1'b0 || deq_bits !== W'(32'h10)) begin
      bad++; $display("FAIL full_no_pipe: got w0en=%0b data=%0h want 0/10", W0_en, deq_bits);
    end
    tick();
    total++; if (count !== 3'd4 || enq_ready !== 1'b1) begin
      bad++; $display("FAIL full_after_deq: got count=%0d ready=%0b want 4/1", count, enq_ready);
    end
    apply(1, 1, 0, W'(32'hBB));
    total++; if (W0_en !== 1'b1 || deq_bits !== W'(32'h11)) begin
      bad++; $display("FAIL full_both_fire: got w0en=%0b data=%0h want 1/11", W0_en, deq_bits);
    end
    tick();
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count_hold: got %0d want 4", count); end
    while (model_q.size() > 0) begin
      apply(0, 1, 0, '0);
      total++; if (deq_bits !== model_q[0]) begin
        bad++; $display("FAIL full_drain: got %0h want %0h", deq_bits, model_q[0]);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    apply(0, 0, 1, '0);
    tick();
    for (int i = 0; i < 12; i++) begin
      apply(1, 0, 0, W'(i));
      total++; if (W0_addr !== A'(i % D)) begin
        bad++; $display("FAIL wrap_w0addr: got %0d want %0d", W0_addr, i % D);
      end
      tick();
      apply(0, 1, 0, '0);
      total++; if (deq_bits !== W'(i) || R0_addr !== A'(i % D)) begin
        bad++; $display("FAIL wrap_deq: got data=%0h addr=%0d want %0h/%0d", deq_bits, R0_addr, i, i % D);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 0, W'(32'h40 + i));
      tick();
    end
    apply(1, 0, 1, W'(32'h77));
    total++; if (W0_en !== 1'b1) begin bad++; $display("FAIL flush_w0en: got %0b want 1", W0_en); end
    tick();
    apply(0, 0, 0, '0);
    total++; if (count !== 3'd0 || deq_valid !== 1'b0 || enq_ready !== 1'b1) begin
      bad++; $display("FAIL flush_state: got count=%0d valid=%0b ready=%0b want 0/0/1", count, deq_valid, enq_ready);
    end
    apply(1, 0, 0, W'(32'h5));
    tick();
    apply(0, 1, 0, '0);
    total++; if (deq_bits !== W'(32'h5) || R0_addr !== 3'd0) begin
      bad++; $display("FAIL flush_restart: got data=%0h addr=%0d want 5/0", deq_bits, R0_addr);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 0, W'(32'h60 + i));
      tick();
    end
    reset = 1'b0;
    apply(1, 0, 0, W'(32'h33));
    total++; if (W0_en !== 1'b0) begin bad++; $display("FAIL rstmid_w0en: got %0b want 0", W0_en); end
    tick();
    reset = 1'b1;
    apply(0, 0, 0, '0);
    total++; if (count !== 3'd0 || deq_valid !== 1'b0 || enq_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_state: got count=%0d valid=%0b ready=%0b want 0/0/1", count, deq_valid, enq_ready);
    end
  endtask

  task automatic test_random();
    logic [95:0] r;
    bit ev, dr, fl;
    for (int c = 0; c < 600; c++) begin
      r  = {$urandom, $urandom, $urandom};
      // Alternate producer-heavy and consumer-heavy phases to reach full and empty often.
      if ((c / 50) % 2 == 0) begin
        ev = $urandom_range(0, 4) != 0;
        dr = $urandom_range(0, 3) == 0;
      end else begin
        ev = $urandom_range(0, 3) == 0;
        dr = $urandom_range(0, 4) != 0;
      end
      fl = $urandom_range(0, 60) == 0;
      apply(ev, dr, fl, r[W-1:0]);
      total++; if (enq_ready !== (model_q.size() < D) || deq_valid !== (model_q.size() > 0)) begin
        bad++; $display("FAIL rand_flags: got ready=%0b valid=%0b want size=%0d", enq_ready, deq_valid, model_q.size());
      end
      total++; if (count !== A'(model_q.size())) begin
        bad++; $display("FAIL rand_count: got %0d want %0d", count, model_q.size());
      end
      total++; if (W0_en !== (ev && model_q.size() < D) || W0_addr !== A'(wr_total % D) || R0_addr !== A'(rd_total % D)) begin
        bad++; $display("FAIL rand_ports: got w0en=%0b w0addr=%0d r0addr=%0d want addrs %0d/%0d",
                        W0_en, W0_addr, R0_addr, wr_total % D, rd_total % D);
      end
      if (model_q.size() > 0) begin
        total++; if (deq_bits !== model_q[0]) begin
          bad++; $display("FAIL rand_data: got %0h want %0h", deq_bits, model_q[0]);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
